// File: rtl/conv_pkg.sv
// Shared types and address-field geometry for the convolution tile loader.
package conv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadInput,
    StLoadKernel,
    StLoadOverlap,
    StWaitCompute
  } load_state_t;

  // Address field widths for each on-chip store.
  localparam int unsigned INPUT_ADDR_W   = 14;
  localparam int unsigned KERNEL_ADDR_W  = 9;
  localparam int unsigned OVERLAP_ADDR_W = 8;

  // wr_addr bit that steers int_mem_we to kernel_mem instead of input_mem.
  localparam int unsigned KERNEL_SEL_BIT = 15;

endpackage

// File: rtl/load_addr_counter.sv
// Up-counter with synchronous clear, enable and terminal-count flag.
// Shared by every load phase; the caller supplies the last index of the phase.
module load_addr_counter #(
  parameter int unsigned Width = 14
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [Width-1:0] i_last,
  output logic [Width-1:0] o_count,
  output logic             o_tc
);

  logic [Width-1:0] r_count;

  // Clear wins over enable so a phase change always restarts at zero.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_last);

endmodule

// File: rtl/tile_load_sequencer.sv
// Tile load sequencer: accepts a host word stream, generates store addresses
// and write strobes in a fixed input -> kernel -> overlap order, then hands the
// tile to compute via data_ready until fsm_done.
module tile_load_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned IO_DATA_WIDTH = 16,
  parameter int unsigned INPUT_WORDS   = 16384,
  parameter int unsigned KERNEL_WORDS  = 512,
  parameter int unsigned OVERLAP_WORDS = 256
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic                     start,
  input  logic                     skip_kernel,
  input  logic [IO_DATA_WIDTH-1:0] b_input,
  input  logic                     b_valid,
  output logic                     b_ready,
  output logic [IO_DATA_WIDTH-1:0] wr_addr,
  output logic [IO_DATA_WIDTH-1:0] wr_data,
  output logic                     int_mem_we,
  output logic                     overlap_cache_we,
  output logic                     data_ready,
  input  logic                     fsm_done,
  output logic                     busy,
  output logic [15:0]              tile_count
);

  localparam logic [INPUT_ADDR_W-1:0] InputLast   = INPUT_ADDR_W'(INPUT_WORDS - 1);
  localparam logic [INPUT_ADDR_W-1:0] KernelLast  = INPUT_ADDR_W'(KERNEL_WORDS - 1);
  localparam logic [INPUT_ADDR_W-1:0] OverlapLast = INPUT_ADDR_W'(OVERLAP_WORDS - 1);

  load_state_t r_state, w_state_next;
  logic        r_skip_kernel;

  logic                     w_accept;
  logic                     w_phase_done;
  logic                     w_cnt_clr;
  logic                     w_cnt_tc;
  logic [INPUT_ADDR_W-1:0]  w_cnt;
  logic [INPUT_ADDR_W-1:0]  w_cnt_last;
  logic [IO_DATA_WIDTH-1:0] w_addr;

  logic [IO_DATA_WIDTH-1:0] r_wr_addr;
  logic [IO_DATA_WIDTH-1:0] r_wr_data;
  logic                     r_int_we;
  logic                     r_ov_we;
  logic                     r_data_ready;
  logic [15:0]              r_tile_count;

  assign b_ready = (r_state == StLoadInput) || (r_state == StLoadKernel) ||
                   (r_state == StLoadOverlap);
  assign w_accept     = b_valid && b_ready;
  assign w_phase_done = w_accept && w_cnt_tc;

  load_addr_counter #(
    .Width (INPUT_ADDR_W)
  ) u_counter (
    .i_clk    (clk),
    .i_arst_n (arst_n_in),
    .i_clr    (w_cnt_clr),
    .i_en     (w_accept),
    .i_last   (w_cnt_last),
    .o_count  (w_cnt),
    .o_tc     (w_cnt_tc)
  );

  // Last word index of the phase currently loading.
  always_comb begin
    w_cnt_last = InputLast;
    case (r_state)
      StLoadKernel:  w_cnt_last = KernelLast;
      StLoadOverlap: w_cnt_last = OverlapLast;
      default:       w_cnt_last = InputLast;
    endcase
  end

  // Next state and counter clear on every phase change.
  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    case (r_state)
      StIdle: begin
        if (start) begin
          w_state_next = StLoadInput;
          w_cnt_clr    = 1'b1;
        end
      end
      StLoadInput: begin
        if (w_phase_done) begin
          w_state_next = r_skip_kernel ? StLoadOverlap : StLoadKernel;
          w_cnt_clr    = 1'b1;
        end
      end
      StLoadKernel: begin
        if (w_phase_done) begin
          w_state_next = StLoadOverlap;
          w_cnt_clr    = 1'b1;
        end
      end
      StLoadOverlap: begin
        if (w_phase_done) begin
          w_state_next = StWaitCompute;
          w_cnt_clr    = 1'b1;
        end
      end
      StWaitCompute: begin
        // A coincident start is dropped; the host must re-issue it.
        if (fsm_done) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State register and skip_kernel latch captured with start.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_state       <= StIdle;
      r_skip_kernel <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == StIdle) && start) begin
        r_skip_kernel <= skip_kernel;
      end
    end
  end

  // Map the shared counter onto the field layout of the active store.
  always_comb begin
    w_addr = '0;
    case (r_state)
      StLoadInput: begin
        w_addr[INPUT_ADDR_W-1:0] = w_cnt;
      end
      StLoadKernel: begin
        w_addr[KERNEL_ADDR_W-1:0] = w_cnt[KERNEL_ADDR_W-1:0];
        w_addr[KERNEL_SEL_BIT]    = 1'b1;
      end
      StLoadOverlap: begin
        w_addr[OVERLAP_ADDR_W-1:0] = w_cnt[OVERLAP_ADDR_W-1:0];
      end
      default: w_addr = '0;
    endcase
  end

  // One-cycle write pipeline: strobe only in the cycle after an accepted word.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_int_we  <= 1'b0;
      r_ov_we   <= 1'b0;
    end else begin
      r_int_we <= w_accept && (r_state != StLoadOverlap);
      r_ov_we  <= w_accept && (r_state == StLoadOverlap);
      if (w_accept) begin
        r_wr_addr <= w_addr;
        r_wr_data <= b_input;
      end
    end
  end

  // data_ready rises only once the final overlap write has been issued.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_data_ready <= 1'b0;
      r_tile_count <= '0;
    end else if (r_state == StWaitCompute) begin
      if (fsm_done) begin
        r_data_ready <= 1'b0;
        r_tile_count <= r_tile_count + 1'b1;
      end else if (r_ov_we) begin
        r_data_ready <= 1'b1;
      end
    end
  end

  assign wr_addr          = r_wr_addr;
  assign wr_data          = r_wr_data;
  assign int_mem_we       = r_int_we;
  assign overlap_cache_we = r_ov_we;
  assign data_ready       = r_data_ready;
  assign busy             = (r_state != StIdle);
  assign tile_count       = r_tile_count;

endmodule

// File: tb/tb_tile_load_sequencer.sv
// Self-checking bench for tile_load_sequencer with a 4/2/2-word tile.
module tb_tile_load_sequencer;

  logic        clk;
  logic        arst_n_in;
  logic        start;
  logic        skip_kernel;
  logic [15:0] b_input;
  logic        b_valid;
  logic        b_ready;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        int_mem_we;
  logic        overlap_cache_we;
  logic        data_ready;
  logic        fsm_done;
  logic        busy;
  logic [15:0] tile_count;

  typedef struct packed {
    logic        ov;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_tiles = 16'h0000;

  tile_load_sequencer #(
    .IO_DATA_WIDTH (16),
    .INPUT_WORDS   (4),
    .KERNEL_WORDS  (2),
    .OVERLAP_WORDS (2)
  ) dut (
    .clk              (clk),
    .arst_n_in        (arst_n_in),
    .start            (start),
    .skip_kernel      (skip_kernel),
    .b_input          (b_input),
    .b_valid          (b_valid),
    .b_ready          (b_ready),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .int_mem_we       (int_mem_we),
    .overlap_cache_we (overlap_cache_we),
    .data_ready       (data_ready),
    .fsm_done         (fsm_done),
    .busy             (busy),
    .tile_count       (tile_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every strobe must match the next expected write.
  always @(negedge clk) begin
    if (arst_n_in && (int_mem_we || overlap_cache_we)) begin
      wr_t e;
      n_checks++;
      if (int_mem_we && overlap_cache_we) begin
        n_fail++;
        $display("FAIL dual_strobe: both strobes high at %0t", $time);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_write: ov=%0b addr=%h data=%h, none expected",
                 overlap_cache_we, wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({overlap_cache_we, wr_addr, wr_data} !== {e.ov, e.addr, e.data}) begin
          n_fail++;
          $display("FAIL write: got ov=%0b addr=%h data=%h, want ov=%0b addr=%h data=%h",
                   overlap_cache_we, wr_addr, wr_data, e.ov, e.addr, e.data);
        end
      end
    end
  end

  // All tasks begin and end 1 time unit after a rising edge.
  task automatic do_start(input bit skip);
    start       = 1'b1;
    skip_kernel = skip;
    @(posedge clk); #1;
    start       = 1'b0;
    skip_kernel = 1'b0;
  endtask

  task automatic feed(input bit skip, input bit gaps, input logic [15:0] base);
    int  n     = skip ? 6 : 8;
    int  k     = 0;
    int  guard = 0;
    wr_t e;
    while (k < n && guard < 200) begin
      if (gaps && $urandom_range(0, 1) == 0) begin
        b_valid = 1'b0;
      end else begin
        b_valid = 1'b1;
        b_input = base + 16'(k);
        e.data  = base + 16'(k);
        if (k < 4) begin
          e.ov = 1'b0; e.addr = 16'(k);
        end else if (!skip && k < 6) begin
          e.ov = 1'b0; e.addr = 16'h8000 | 16'(k - 4);
        end else begin
          e.ov = 1'b1; e.addr = 16'(k - (skip ? 4 : 6));
        end
        exp_q.push_back(e);
        n_checks++;
        if (b_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b_ready_load: word %0d b_ready=%b want 1", k, b_ready);
        end
        k++;
      end
      @(posedge clk); #1;
      guard++;
    end
    b_valid = 1'b0;
    b_input = 16'h0;
    n_checks++;
    if (k != n) begin
      n_fail++;
      $display("FAIL feed_timeout: sent %0d words want %0d", k, n);
    end
    @(negedge clk);
    n_checks++;
    if ({b_ready, data_ready, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL last_write_cycle: b_ready=%b data_ready=%b busy=%b want 0 0 1",
               b_ready, data_ready, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (data_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL data_ready_rise: data_ready=%b want 1", data_ready);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_writes: %0d writes outstanding want 0", exp_q.size());
    end
  endtask

  task automatic compute_done();
    fsm_done = 1'b1;
    @(posedge clk); #1;
    fsm_done  = 1'b0;
    exp_tiles = exp_tiles + 16'd1;
    n_checks++;
    if ({data_ready, busy, tile_count} !== {1'b0, 1'b0, exp_tiles}) begin
      n_fail++;
      $display("FAIL compute_done: data_ready=%b busy=%b tile_count=%h want 0 0 %h",
               data_ready, busy, tile_count, exp_tiles);
    end
  endtask

  task automatic test_reset();
    wr_t e;
    n_checks++;
    if ({b_ready, wr_addr, wr_data, int_mem_we, overlap_cache_we, data_ready, busy,
         tile_count} !== 54'h0) begin
      n_fail++;
      $display("FAIL reset_state: outputs not all zero busy=%b tile_count=%h", busy,
               tile_count);
    end
    do_start(1'b0);
    for (int k = 0; k < 3; k++) begin
      b_valid = 1'b1;
      b_input = 16'h00A0 + 16'(k);
      e.ov = 1'b0; e.addr = 16'(k); e.data = 16'h00A0 + 16'(k);
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    #2 arst_n_in = 1'b0;
    #1;
    n_checks++;
    if ({b_ready, wr_addr, wr_data, int_mem_we, overlap_cache_we, data_ready, busy,
         tile_count} !== 54'h0) begin
      n_fail++;
      $display("FAIL reset_midload: busy=%b we=%b ov_we=%b addr=%h want all zero",
               busy, int_mem_we, overlap_cache_we, wr_addr);
    end
    exp_q.delete();
    #3 arst_n_in = 1'b1;
    // b_valid still high while idle: nothing may be accepted.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({b_ready, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_after_reset: b_ready=%b busy=%b want 0 0", b_ready, busy);
      end
    end
    b_valid = 1'b0;
  endtask

  task automatic test_full_load();
    do_start(1'b0);
    feed(1'b0, 1'b0, 16'h0010);
    compute_done();
  endtask

  task automatic test_skip_kernel();
    do_start(1'b1);
    feed(1'b1, 1'b0, 16'h0010);
    compute_done();
  endtask

  task automatic test_gaps();
    do_start(1'b0);
    feed(1'b0, 1'b1, 16'h0010);
    compute_done();
  endtask

  task automatic test_wait_compute();
    // fsm_done while idle is ignored.
    fsm_done = 1'b1;
    @(posedge clk); #1;
    fsm_done = 1'b0;
    n_checks++;
    if ({busy, tile_count} !== {1'b0, exp_tiles}) begin
      n_fail++;
      $display("FAIL done_in_idle: busy=%b tile_count=%h want 0 %h", busy, tile_count,
               exp_tiles);
    end
    do_start(1'b1);
    feed(1'b1, 1'b0, 16'h0030);
    // start while busy is ignored.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, data_ready, b_ready} !== 3'b110) begin
      n_fail++;
      $display("FAIL start_in_wait: busy=%b data_ready=%b b_ready=%b want 1 1 0",
               busy, data_ready, b_ready);
    end
    compute_done();
  endtask

  task automatic test_back_to_back();
    do_start(1'b0);
    n_checks++;
    if ({busy, b_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL back_to_back_start: busy=%b b_ready=%b want 1 1", busy, b_ready);
    end
    feed(1'b0, 1'b1, 16'h0050);
    // Coincident start and fsm_done: go idle, start dropped.
    start    = 1'b1;
    fsm_done = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    fsm_done  = 1'b0;
    exp_tiles = exp_tiles + 16'd1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, data_ready, tile_count} !== {1'b0, 1'b0, exp_tiles}) begin
      n_fail++;
      $display("FAIL start_with_done: busy=%b data_ready=%b tile_count=%h want 0 0 %h",
               busy, data_ready, tile_count, exp_tiles);
    end
  endtask

  task automatic test_wrap();
    force dut.r_tile_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_tile_count;
    @(posedge clk); #1;
    exp_tiles = 16'hFFFF;
    do_start(1'b1);
    feed(1'b1, 1'b0, 16'h0070);
    compute_done();
  endtask

  initial begin
    arst_n_in   = 1'b0;
    start       = 1'b0;
    skip_kernel = 1'b0;
    b_input     = 16'h0;
    b_valid     = 1'b0;
    fsm_done    = 1'b0;
    repeat (3) @(posedge clk);
    #1 arst_n_in = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_full_load();
    test_skip_kernel();
    test_gaps();
    test_wait_compute();
    test_back_to_back();
    test_wrap();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_load_sequencer.md
Name: tile_load_sequencer

Overview:
- Front-end sequencer for one convolution tile: takes a host data stream on the b valid/ready channel and generates write addresses and enables for the three on-chip stores (input_mem, kernel_mem, overlap_cache).
- After the tile is loaded it raises data_ready to the compute controller and holds it until that controller pulses fsm_done, then returns to idle for the next tile.
- Sits between the host/testbench interface and the top-level write ports. It replaces host-supplied addressing with a fixed, counter-generated load order.

Parameters:
- IO_DATA_WIDTH, 16, width of data words and of the generated write address.
- INPUT_WORDS, 16384, words per input tile; address = {inch[0], y[6:0], x[5:0]}; must be at most 2^14.
- KERNEL_WORDS, 512, words per kernel set; address = {inch[0], ky[1:0], kx[1:0], outch[3:0]}; must be at most 2^9.
- OVERLAP_WORDS, 256, words per overlap-cache column; address = {inch[0], y[6:0]}; must be at most 2^8.

Ports:
- clk  in  1  system clock
- arst_n_in  in  1  asynchronous reset, active low
- start  in  1  single-cycle request to load one tile
- skip_kernel  in  1  sampled with start; 1 = keep the resident kernels and skip LOAD_KERNEL
- b_input  in  IO_DATA_WIDTH  host data word
- b_valid  in  1  host data valid
- b_ready  out  1  sequencer can accept a word
- wr_addr  out  IO_DATA_WIDTH  store address; bit 15 = 1 selects kernel_mem
- wr_data  out  IO_DATA_WIDTH  registered copy of the accepted word
- int_mem_we  out  1  write strobe for input_mem or kernel_mem (selected by wr_addr[15])
- overlap_cache_we  out  1  write strobe for overlap_cache
- data_ready  out  1  tile resident; compute may run
- fsm_done  in  1  compute controller finished the tile
- busy  out  1  state is not IDLE
- tile_count  out  16  tiles completed, wraps at 2^16

Behaviour:
- Reset values: every output is 0 and the state is IDLE. An asynchronous reset mid-load aborts the load with no partial-write completion. Memory contents are untouched.
- States: IDLE -> LOAD_INPUT -> LOAD_KERNEL -> LOAD_OVERLAP -> WAIT_COMPUTE -> IDLE.
  - IDLE -> LOAD_INPUT on start. skip_kernel is latched at the same time.
  - LOAD_INPUT -> LOAD_KERNEL when the INPUT_WORDS-th word is accepted. If skip_kernel was latched, it goes directly to LOAD_OVERLAP instead.
  - LOAD_KERNEL -> LOAD_OVERLAP when the KERNEL_WORDS-th word is accepted.
  - LOAD_OVERLAP -> WAIT_COMPUTE when the OVERLAP_WORDS-th word is accepted.
  - WAIT_COMPUTE -> IDLE on fsm_done. tile_count increments on the same edge.
- Handshake:
  - b_ready = 1 only in the three LOAD states. It is combinational from state.
  - A word is accepted on a clock edge where b_valid && b_ready. The host may drop b_valid at any time; the counter simply stalls.
  - b_ready stays high on the final word of each phase. b_ready drops in the cycle after the last overlap word.
- Write pipeline, latency 1:
  - In the cycle after acceptance, wr_data = accepted word, wr_addr = phase counter value, and exactly one strobe is high.
  - Strobe selection: int_mem_we with wr_addr[15] = 0 in LOAD_INPUT; int_mem_we with wr_addr[15] = 1 in LOAD_KERNEL; overlap_cache_we in LOAD_OVERLAP.
  - Strobes are low when no word was accepted in the previous cycle.
  - Unused high address bits are zero.
- Counter: one shared word counter. It clears at every phase change and holds while the handshake stalls.
- data_ready:
  - Set in the cycle after the last overlap write has issued, so it never precedes a pending write.
  - Held through WAIT_COMPUTE; cleared on the fsm_done edge.
- Ignored events:
  - start while busy is ignored.
  - fsm_done outside WAIT_COMPUTE is ignored.
  - b_valid in IDLE or WAIT_COMPUTE is not accepted.
- Simultaneous start and fsm_done in WAIT_COMPUTE: the state goes to IDLE and start is ignored. The host must re-issue start.
- Back-to-back tiles: start in the cycle immediately after the return to IDLE begins the next load.

Decomposition:
- Shared package (conv_pkg):
  - load_state_t enum.
  - Address-field widths: INPUT_ADDR_W = 14, KERNEL_ADDR_W = 9, OVERLAP_ADDR_W = 8.
  - KERNEL_SEL_BIT = 15.
- One natural sub-module: load_addr_counter. It is a parameterised up-counter with clear, enable and a terminal-count flag, shared by all phases.

Test Plan:
- Reset mid-LOAD_INPUT, then release -> all outputs 0, state IDLE, no further strobes.
- INPUT_WORDS=4, KERNEL_WORDS=2, OVERLAP_WORDS=2; start; 8 words 0x10..0x17 with b_valid held high:
  - int_mem_we at addresses 0x0000–0x0003 with data 0x10–0x13;
  - kernel writes at 0x8000–0x8001 with data 0x14–0x15;
  - overlap writes at 0x0000–0x0001 with data 0x16–0x17;
  - data_ready one cycle after the last write.
- Same configuration with skip_kernel=1 and 6 words -> no wr_addr[15] write; data_ready after the 6th word.
- Random b_valid gaps, 50% duty -> same address/data sequence as the gapless run; no strobe in stall cycles.
- In WAIT_COMPUTE: a start pulse is ignored; fsm_done clears data_ready and tile_count goes 0 -> 1; a start on the next cycle begins a new load.
- Preload tile_count = 0xFFFF via 65535 short tiles, or force -> the next fsm_done wraps it to 0x0000.
